// File: rtl/pd_pkg.sv
// Shared types and helpers for the priority decoder pipeline: widths, skid state
// encoding, the encoded token layout and the one-hot decode function.
package pd_pkg;
  localparam int PD_IDX_W = 2;
  localparam int N        = 2**PD_IDX_W;

  // Encoding doubles as the handshake flags: bit1 = out_valid, bit0 = in_ready.
  typedef enum logic [1:0] {
    EMPTY = 2'b01,
    ONE   = 2'b11,
    FULL  = 2'b10
  } skid_state_e;

  typedef struct packed {
    logic [PD_IDX_W-1:0] idx;
    logic                zero;
  } token_t;

  // A zero token never looks at idx, so unknown index bits cannot leak through.
  function automatic logic [N-1:0] decode_onehot(input logic [PD_IDX_W-1:0] idx,
                                                 input logic zero);
    logic [N-1:0] v;
    v = '0;
    if (!zero) v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/pd_skid_buffer.sv
// Generic 2-entry valid/ready buffer. Handshake: a word moves when valid & ready
// are both high at a rising edge; ready and valid come straight from state flops.
module pd_skid_buffer
  import pd_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output skid_state_e      state
);
  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_xfer, out_xfer;

  assign in_xfer  = in_valid & state_q[0];
  assign out_xfer = out_ready & state_q[1];

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_data = main_q;
  assign state    = state_q;
endmodule

// File: rtl/priority_decoder_pipe.sv
// Registered decoder from {index, zero} tokens back to one-hot request vectors,
// with a sticky mask of decoded lines and a saturating zero-token counter.
module priority_decoder_pipe
  import pd_pkg::*;
#(
  parameter int IDX_W = PD_IDX_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_onehot,
  input  logic             clear_mask,
  output logic [N-1:0]     seen_mask,
  output logic [CNT_W-1:0] zero_count
);
  localparam logic [CNT_W-1:0] ZC_MAX = '1;

  token_t      tok;
  logic [N-1:0] decoded;
  skid_state_e skid_state;
  logic        in_xfer, out_xfer;

  assign tok     = '{idx: in_idx, zero: in_zero};
  assign decoded = decode_onehot(tok.idx, tok.zero);

  pd_skid_buffer #(.W(N)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (decoded),
    .out_ready (out_ready),
    .out_data  (out_onehot),
    .state     (skid_state)
  );

  assign in_ready  = skid_state[0];
  assign out_valid = skid_state[1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Clear takes effect before the set, so a colliding transfer survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_mask <= '0;
    end else if (clear_mask) begin
      seen_mask <= out_xfer ? out_onehot : '0;
    end else if (out_xfer) begin
      seen_mask <= seen_mask | out_onehot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_count <= '0;
    end else if (in_xfer && tok.zero && (zero_count != ZC_MAX)) begin
      zero_count <= zero_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_priority_decoder_pipe.sv
// Bench for priority_decoder_pipe: directed scenarios plus randomized traffic,
// checked by a queue-based scoreboard and a behavioural model of the status outputs.
module tb_priority_decoder_pipe;
  localparam int IDX_W = 2;
  localparam int NB    = 4;
  localparam int CNT_W = 2;
  localparam int ZMAX  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_zero;
  logic             out_valid;
  logic             out_ready;
  logic [NB-1:0]    out_onehot;
  logic             clear_mask;
  logic [NB-1:0]    seen_mask;
  logic [CNT_W-1:0] zero_count;

  logic [NB-1:0] exp_q[$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;
  int            model_seen = 0;
  int            model_zc   = 0;
  bit            rand_phase = 0;

  priority_decoder_pipe #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .clear_mask (clear_mask),
    .seen_mask  (seen_mask),
    .zero_count (zero_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // driver tasks: inputs change at posedge+1
  task automatic send(input int idx, input bit zero);
    bit accepted = 0;
    in_valid = 1'b1;
    in_idx   = IDX_W'(idx);
    in_zero  = zero;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(zero ? NB'(0) : NB'(1 << idx));
        accepted = 1;
        break;
      end
    end
    if (!accepted) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // scoreboard / monitor: compare at negedge, then model what the next edge does
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_seen = 0;
      model_zc   = 0;
    end else begin
      check("seen_mask", int'(seen_mask), model_seen);
      check("zero_count", int'(zero_count), model_zc);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", int'(out_onehot), -1);
        end else begin
          check("out_onehot", int'(out_onehot), int'(exp_q[0]));
          if (out_ready) begin
            if (clear_mask) model_seen = int'(exp_q[0]);
            else            model_seen = model_seen | int'(exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
      end
      if (clear_mask && !(out_valid && out_ready)) model_seen = 0;
      if (in_valid && in_ready && in_zero && model_zc < ZMAX) model_zc++;
    end
  end

  always @(posedge clk) begin
    if (rand_phase) begin
      #1;
      out_ready  = ($urandom_range(0, 3) != 0);
      clear_mask = ($urandom_range(0, 15) == 0);
    end
  end

  initial begin
    int  t0;
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_zero = 1'b0;
    out_ready = 1'b0; clear_mask = 1'b0;
    cycles(2);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_onehot", int'(out_onehot), 0);
    check("rst_seen", int'(seen_mask), 0);
    check("rst_zc", int'(zero_count), 0);
    rst = 1'b0;
    cycles(1);

    // single token
    out_ready = 1'b1;
    send(2, 0);
    check("single_valid", int'(out_valid), 1);
    check("single_onehot", int'(out_onehot), 4'b0100);
    cycles(1);
    check("single_seen", int'(seen_mask), 4'b0100);

    // zero token with a nonzero index
    send(3, 1);
    check("zero_onehot", int'(out_onehot), 0);
    cycles(1);
    check("zero_count1", int'(zero_count), 1);
    check("zero_seen", int'(seen_mask), 4'b0100);

    // back-pressure
    out_ready = 1'b0;
    send(0, 0);
    send(1, 0);
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_hold", int'(out_onehot), 4'b0001);
    fork
      send(2, 0);
      begin
        cycles(3);
        check("bp_still_hold", int'(out_onehot), 4'b0001);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_back", int'(in_ready), 1);

    // streaming
    t0 = int'($time);
    for (int i = 0; i < 16; i++) send(i % 4, 0);
    check("stream_cycles", (int'($time) - t0) / 10, 16);
    drain();
    check("stream_seen", int'(seen_mask), 4'b1111);

    // clear alone, then clear colliding with an output transfer
    clear_mask = 1'b1; cycles(1); clear_mask = 1'b0;
    check("clear_alone", int'(seen_mask), 0);
    for (int i = 0; i < 4; i++) send(i, 0);
    drain();
    out_ready = 1'b0;
    send(1, 0);
    clear_mask = 1'b1; out_ready = 1'b1;
    cycles(1);
    clear_mask = 1'b0;
    check("clear_collision", int'(seen_mask), 4'b0010);

    // zero token with an unknown index
    in_valid = 1'b1; in_zero = 1'b1; in_idx = 'x;
    @(negedge clk);
    if (in_ready) exp_q.push_back('0);
    cycles(1);
    in_valid = 1'b0; in_idx = '0;
    check("x_idx_onehot", int'(out_onehot), 0);
    drain();

    // randomized traffic
    rand_phase = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) cycles(1);
      else send($urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end
    rand_phase = 0;
    #1; out_ready = 1'b1; clear_mask = 1'b0;
    drain();

    // saturation
    for (int i = 0; i < 5; i++) send(0, 1);
    drain();
    check("zc_saturated", int'(zero_count), ZMAX);

    // asynchronous reset between edges while FULL
    out_ready = 1'b0;
    send(1, 0);
    send(2, 0);
    check("full_in_ready", int'(in_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_onehot", int'(out_onehot), 0);
    check("async_zc", int'(zero_count), 0);
    check("async_in_ready", int'(in_ready), 1);
    cycles(2);
    rst = 1'b0;
    out_ready = 1'b1;
    cycles(3);
    check("post_rst_valid", int'(out_valid), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/priority_decoder_pipe.md
Name: priority_decoder_pipe

Overview:
- Receive-side counterpart of the team's priority encoder: accepts encoded tokens {index, zero flag} and regenerates the one-hot request vector.
- Registered, with a valid/ready handshake and a 2-entry skid buffer, so it can sit between pipeline stages at full throughput.
- Also keeps a sticky mask of every decoded line and a saturating count of "no request" (zero) tokens for status and debug.

Parameters:
IDX_W, 2, width of encoded index; number of one-hot lines N = 2**IDX_W
CNT_W, 8, width of the saturating zero-token counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  encoded token present
in_ready  output  1  block can accept a token this cycle
in_idx  input  IDX_W  encoded index of the highest-priority request
in_zero  input  1  1 = no request active; in_idx is ignored
out_valid  output  1  decoded vector present
out_ready  input  1  downstream accepts the vector this cycle
out_onehot  output  N  decoded vector: one-hot, or all-zero for a zero token
clear_mask  input  1  synchronous clear of seen_mask
seen_mask  output  N  OR of every out_onehot transferred since reset or clear
zero_count  output  CNT_W  number of accepted zero tokens, saturating

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst); its polarity and synchronicity are fixed.
- Reset values: out_valid=0, out_onehot=0, in_ready=1, seen_mask=0, zero_count=0, skid entry empty.
  - Reset asserted mid-operation immediately discards the main and skid entries.
  - No transfer completes while rst=1.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_onehot and out_valid are driven straight from flops; there is no combinational path from in_* to out_*.
  - in_ready is a register and does not depend combinationally on out_ready.
- Decode function:
  - in_zero=1 gives all zeros.
  - Otherwise bit in_idx is set and all other bits are clear.
  - Decoding happens on input transfer; the registered result is what gets stored.
- Latency: an accepted token appears on out_onehot with out_valid=1 on the next clock edge when the main entry is free. Sustained throughput is 1 token/cycle.
- Skid state machine, states EMPTY, ONE, FULL:
  - EMPTY (out_valid=0, in_ready=1): input transfer goes to ONE, loading the main entry.
  - ONE (out_valid=1, in_ready=1):
    - input and output transfer together: stay in ONE, main entry reloads.
    - input transfer only: go to FULL, token is stored in the skid entry.
    - output transfer only: go to EMPTY.
  - FULL (out_valid=1, in_ready=0): output transfer goes to ONE, skid entry moves to main. No input transfer is possible.
- Ordering: tokens leave in acceptance order. None is dropped or duplicated.
- Stall: while out_valid=1 and out_ready=0, out_onehot holds stable.
- seen_mask:
  - Updated on output transfer: seen_mask |= out_onehot.
  - clear_mask alone: seen_mask becomes 0 next cycle.
  - clear_mask in the same cycle as an output transfer: seen_mask becomes exactly that out_onehot (clear first, then set).
  - A zero token leaves seen_mask unchanged.
- zero_count:
  - Increments on input transfer with in_zero=1.
  - Holds at 2**CNT_W-1 once reached, with no wrap.
  - Cleared only by rst.
- Boundaries:
  - in_idx with X bits while in_zero=1 must not corrupt out_onehot; it must be all-zero.
  - in_valid may be deasserted without a transfer. There is no input hold obligation on the sender.

Decomposition:
- Package pd_pkg holds:
  - localparam N derived from IDX_W;
  - the skid state enum (EMPTY, ONE, FULL);
  - the function decode_onehot(idx, zero) returning N bits;
  - the token struct {idx, zero}.
- One sub-module is natural: pd_skid_buffer.
  - Generic 2-entry valid/ready buffer parameterised on data width, carrying the decoded vector.
  - The top level adds the decode, seen_mask and zero_count logic.

Test Plan:
- Reset and single token: assert rst, then send one token with in_idx=2, in_zero=0, out_ready=1. Expect in_ready=1 and outputs at reset values after reset; one cycle later out_valid=1, out_onehot=4'b0100; seen_mask=4'b0100 after the transfer.
- Zero token: send in_zero=1, in_idx=3. Expect out_onehot=4'b0000, zero_count=1, seen_mask unchanged.
- Back-pressure: tokens idx 0,1,2 on consecutive cycles with out_ready=0. Expect in_ready to fall to 0 after the second is accepted and out_onehot to hold 4'b0001. Then set out_ready=1: outputs 0001, 0010, 0100 in order, and in_ready returns to 1.
- Streaming: 16 back-to-back tokens idx 0,1,2,3 repeating, with out_ready=1. Expect one output per cycle after 1-cycle latency and seen_mask=4'b1111.
- Clear collision: seen_mask=4'b1111, then clear_mask=1 in the same cycle as an output transfer of 4'b0010. Expect seen_mask=4'b0010.
- Saturation and async reset: with CNT_W=2, send 5 zero tokens and expect zero_count=3. Assert rst between clock edges while in FULL: expect out_valid=0 and zero_count=0 immediately, before the next edge.
